controlador_memoria_instrucoes: RTL and testbench

//  Owns the instruction memory write/read port: boots it from a loader stream, then serves CPU fetches.

---
 rtl/controlador_memoria_instrucoes.sv | 175 +++++++++++++++++
 tb/tb_controlador_memoria_instrucoes.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_memoria_instrucoes.sv
// Instruction-memory port controller: boots memory from a loader stream, then serves CPU fetches until HALT.
// Optional build macro CICLOS_EXEC_EN enables the EXEC-cycle counter on ciclos_exec.
module controlador_memoria_instrucoes #(
    parameter int         PROFUNDIDADE = 141,
    parameter int         END_INICIAL  = 1,
    parameter logic [4:0] OPCODE_HALT  = 5'd18
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        carga_valido,
    input  logic [31:0] carga_dado,
    input  logic        carga_fim,
    output logic        carga_pronto,
    input  logic        busca_req,
    input  logic [31:0] busca_endereco,
    output logic        busca_ack,
    output logic [31:0] busca_instrucao,
    output logic [31:0] mem_endereco,
    output logic [31:0] mem_dado,
    output logic        mem_escrita,
    input  logic [31:0] mem_instrucao,
    output logic        cpu_habilitado,
    output logic        parado,
    output logic        erro_endereco,
    output logic [9:0]  palavras_carregadas,
    output logic [31:0] ciclos_exec
);

    typedef enum logic [1:0] {
        CARGA  = 2'd0,
        EXEC   = 2'd1,
        PARADO = 2'd2
    } estado_t;

    localparam logic [9:0]  PONTEIRO_INICIAL = 10'(END_INICIAL);
    localparam logic [9:0]  PONTEIRO_ULTIMO  = 10'(PROFUNDIDADE - 1);
    localparam logic [31:0] LIMITE_ENDERECO  = 32'(PROFUNDIDADE);

    estado_t     estado_q, estado_d;
    logic [9:0]  ponteiro_q, ponteiro_d;
    logic [9:0]  palavras_q, palavras_d;
    logic        ack_q, ack_d;
    logic [31:0] instr_q, instr_d;
    logic        erro_q, erro_d;

    logic        pronto;
    logic        aceita;
    logic        halt_visto;
    logic        busca_aceita;
    logic        fora_limite;
    logic        recarga;

    assign pronto       = (estado_q == CARGA);
    // Reset also suppresses the write strobe so a word presented during reset never lands in memory.
    assign aceita       = carga_valido & pronto & ~reset;
    assign halt_visto   = ack_q & (instr_q[31:27] == OPCODE_HALT);
    // No new fetch is taken while the HALT response is on the bus; the CPU is being stopped.
    assign busca_aceita = (estado_q == EXEC) & busca_req & ~halt_visto;
    assign fora_limite  = (busca_endereco >= LIMITE_ENDERECO);
    assign recarga      = (estado_q == PARADO) & carga_valido;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= CARGA;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            CARGA: begin
                if (aceita && (carga_fim || (ponteiro_q == PONTEIRO_ULTIMO))) begin
                    estado_d = EXEC;
                end
            end
            EXEC: begin
                if (halt_visto) begin
                    estado_d = PARADO;
                end
            end
            PARADO: begin
                if (carga_valido) begin
                    estado_d = CARGA;
                end
            end
            default: estado_d = CARGA;
        endcase
    end

    // Output logic
    always_comb begin
        carga_pronto   = pronto;
        cpu_habilitado = (estado_q == EXEC);
        parado         = (estado_q == PARADO);
        mem_escrita    = aceita;
        mem_dado       = aceita ? carga_dado : 32'h0;
        case (estado_q)
            CARGA:   mem_endereco = {22'h0, ponteiro_q};
            EXEC:    mem_endereco = busca_endereco;
            default: mem_endereco = 32'h0;
        endcase
    end

    // Datapath next-state: load pointer/count, fetch response, sticky address error
    always_comb begin
        ponteiro_d = ponteiro_q;
        palavras_d = palavras_q;
        if (aceita) begin
            ponteiro_d = ponteiro_q + 10'd1;
            palavras_d = palavras_q + 10'd1;
        end
        if (recarga) begin
            ponteiro_d = PONTEIRO_INICIAL;
            palavras_d = 10'd0;
        end
        ack_d   = busca_aceita;
        instr_d = 32'h0;
        if (busca_aceita && !fora_limite) begin
            instr_d = mem_instrucao;
        end
        erro_d = erro_q | (busca_aceita & fora_limite);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ponteiro_q <= PONTEIRO_INICIAL;
            palavras_q <= 10'd0;
            ack_q      <= 1'b0;
            instr_q    <= 32'h0;
            erro_q     <= 1'b0;
        end else begin
            ponteiro_q <= ponteiro_d;
            palavras_q <= palavras_d;
            ack_q      <= ack_d;
            instr_q    <= instr_d;
            erro_q     <= erro_d;
        end
    end

    assign busca_ack           = ack_q;
    assign busca_instrucao     = instr_q;
    assign erro_endereco       = erro_q;
    assign palavras_carregadas = palavras_q;

`ifdef CICLOS_EXEC_EN
    logic [31:0] ciclos_q, ciclos_d;

    // Free-running wrap at 2^32; restarts with each new program load.
    always_comb begin
        ciclos_d = ciclos_q;
        if (estado_q == EXEC) begin
            ciclos_d = ciclos_q + 32'd1;
        end else if (recarga) begin
            ciclos_d = 32'h0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ciclos_q <= 32'h0;
        end else begin
            ciclos_q <= ciclos_d;
        end
    end

    assign ciclos_exec = ciclos_q;
`else
    assign ciclos_exec = 32'h0;
`endif

endmodule

// File: tb/tb_controlador_memoria_instrucoes.sv
// Scoreboard bench for controlador_memoria_instrucoes with a behavioural combinational-read instruction memory.
module tb_controlador_memoria_instrucoes;

    logic        clock = 1'b0;
    logic        reset;
    logic        carga_valido;
    logic [31:0] carga_dado;
    logic        carga_fim;
    logic        carga_pronto;
    logic        busca_req;
    logic [31:0] busca_endereco;
    logic        busca_ack;
    logic [31:0] busca_instrucao;
    logic [31:0] mem_endereco;
    logic [31:0] mem_dado;
    logic        mem_escrita;
    logic [31:0] mem_instrucao;
    logic        cpu_habilitado;
    logic        parado;
    logic        erro_endereco;
    logic [9:0]  palavras_carregadas;
    logic [31:0] ciclos_exec;

    int tests = 0;
    int fails = 0;
    int ack_count = 0;
    int mptr = 1;

    logic [63:0] wq[$];
    logic [31:0] fq[$];
    logic [31:0] tb_mem [0:1023];
    logic [31:0] exp_mem [0:1023];

    controlador_memoria_instrucoes dut (
        .clock               (clock),
        .reset               (reset),
        .carga_valido        (carga_valido),
        .carga_dado          (carga_dado),
        .carga_fim           (carga_fim),
        .carga_pronto        (carga_pronto),
        .busca_req           (busca_req),
        .busca_endereco      (busca_endereco),
        .busca_ack           (busca_ack),
        .busca_instrucao     (busca_instrucao),
        .mem_endereco        (mem_endereco),
        .mem_dado            (mem_dado),
        .mem_escrita         (mem_escrita),
        .mem_instrucao       (mem_instrucao),
        .cpu_habilitado      (cpu_habilitado),
        .parado              (parado),
        .erro_endereco       (erro_endereco),
        .palavras_carregadas (palavras_carregadas),
        .ciclos_exec         (ciclos_exec)
    );

    always #5 clock = ~clock;

    // Behavioural memory: synchronous write, combinational read on the low 10 address bits
    always @(posedge clock) begin
        if (mem_escrita === 1'b1) tb_mem[mem_endereco[9:0]] <= mem_dado;
    end
    assign mem_instrucao = tb_mem[mem_endereco[9:0]];

    // Monitor: pops write and fetch scoreboards as the DUT produces them
    always @(negedge clock) begin
        logic [63:0] ew;
        logic [31:0] ef;
        if (mem_escrita === 1'b1) begin
            tests++;
            if (wq.size() == 0) begin
                fails++;
                $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", mem_endereco, mem_dado);
            end else begin
                ew = wq.pop_front();
                if ({mem_endereco, mem_dado} !== ew) begin
                    fails++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             mem_endereco, mem_dado, ew[63:32], ew[31:0]);
                end else begin
                    $display("[TB] write addr=%0d data=%h", mem_endereco, mem_dado);
                end
            end
        end
        if (busca_ack === 1'b1) begin
            tests++;
            ack_count++;
            if (fq.size() == 0) begin
                fails++;
                $display("FAIL ack_unexpected: got ack instr=%h, required no ack", busca_instrucao);
            end else begin
                ef = fq.pop_front();
                if (busca_instrucao !== ef) begin
                    fails++;
                    $display("FAIL fetch: got %h, required %h", busca_instrucao, ef);
                end else begin
                    $display("[TB] fetch ack instr=%h", busca_instrucao);
                end
            end
        end
    end

    function automatic logic [31:0] esperado(input logic [31:0] a);
        return (a < 32'd141) ? exp_mem[a[9:0]] : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [31:0] d, input logic fim);
        carga_valido = 1'b1;
        carga_dado   = d;
        carga_fim    = fim;
        wq.push_back({32'(mptr), d});
        exp_mem[mptr] = d;
        mptr++;
        tick();
    endtask

    task automatic fetch(input logic [31:0] a);
        busca_req      = 1'b1;
        busca_endereco = a;
        fq.push_back(esperado(a));
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; carga_valido = 1'b0; carga_fim = 1'b0; carga_dado = 32'h0;
        busca_req = 1'b0; busca_endereco = 32'h0;
        tick(); tick();
        reset = 1'b0;
        mptr = 1;
        tests++;
        if ({carga_pronto, cpu_habilitado, parado, busca_ack, erro_endereco, mem_escrita} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_flags: got %b, required 100000",
                     {carga_pronto, cpu_habilitado, parado, busca_ack, erro_endereco, mem_escrita});
        end
        tests++;
        if (palavras_carregadas !== 10'd0) begin
            fails++; $display("FAIL reset_palavras: got %0d, required 0", palavras_carregadas);
        end
        tests++;
        if (ciclos_exec !== 32'd0) begin
            fails++; $display("FAIL reset_ciclos: got %0d, required 0", ciclos_exec);
        end
    endtask

    task automatic test_load();
        load_word(32'hC840_0000, 1'b0);
        load_word(32'hC040_0005, 1'b0);
        load_word(32'h9200_0000, 1'b1);
        carga_valido = 1'b0; carga_fim = 1'b0;
        tests++;
        if ({cpu_habilitado, carga_pronto} !== 2'b10) begin
            fails++; $display("FAIL load_exec: got hab/pronto=%b, required 10", {cpu_habilitado, carga_pronto});
        end
        tests++;
        if (palavras_carregadas !== 10'd3) begin
            fails++; $display("FAIL load_palavras: got %0d, required 3", palavras_carregadas);
        end
        tests++;
        if (wq.size() != 0) begin
            fails++; $display("FAIL load_writes: got %0d pending, required 0", wq.size());
        end
    endtask

    task automatic test_fetch_latency();
        fetch(32'd2);
        busca_req = 1'b0;
        tests++;
        if ({busca_ack, busca_instrucao} !== {1'b1, 32'hC040_0005}) begin
            fails++; $display("FAIL fetch_latency: got ack=%b instr=%h, required ack=1 instr=c0400005",
                              busca_ack, busca_instrucao);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int a0;
        a0 = ack_count;
        fetch(32'd1); fetch(32'd2); fetch(32'd1); fetch(32'd2);
        busca_req = 1'b0;
        tick();
        tests++;
        if (ack_count - a0 != 4) begin
            fails++; $display("FAIL b2b_acks: got %0d, required 4", ack_count - a0);
        end
        tests++;
        if (fq.size() != 0) begin
            fails++; $display("FAIL b2b_pending: got %0d, required 0", fq.size());
        end
    endtask

    task automatic test_addr_error();
        tests++;
        if (erro_endereco !== 1'b0) begin
            fails++; $display("FAIL erro_initial: got %b, required 0", erro_endereco);
        end
        fetch(32'd200);
        busca_req = 1'b0;
        tests++;
        if (erro_endereco !== 1'b1) begin
            fails++; $display("FAIL erro_set: got %b, required 1", erro_endereco);
        end
        fetch(32'd1026);
        fetch(32'd1);
        busca_req = 1'b0;
        tick();
        tests++;
        if (erro_endereco !== 1'b1) begin
            fails++; $display("FAIL erro_sticky: got %b, required 1", erro_endereco);
        end
    endtask

    task automatic test_halt();
        int a0;
        fetch(32'd3);
        busca_req = 1'b0;
        tests++;
        if ({busca_ack, parado} !== 2'b10) begin
            fails++; $display("FAIL halt_ack: got ack/parado=%b, required 10", {busca_ack, parado});
        end
        tick();
        tests++;
        if ({parado, cpu_habilitado} !== 2'b10) begin
            fails++; $display("FAIL halt_state: got parado/hab=%b, required 10", {parado, cpu_habilitado});
        end
        a0 = ack_count;
        busca_req = 1'b1; busca_endereco = 32'd1;
        tick(); tick(); tick();
        tests++;
        if (mem_endereco !== 32'd0) begin
            fails++; $display("FAIL halt_mem_endereco: got %0d, required 0", mem_endereco);
        end
        busca_req = 1'b0;
        tick();
        tests++;
        if (ack_count != a0) begin
            fails++; $display("FAIL halt_no_ack: got %0d acks, required 0", ack_count - a0);
        end
    endtask

    task automatic test_full_load();
        carga_valido = 1'b1; carga_dado = 32'h1000_0000; carga_fim = 1'b0;
        tick();
        tests++;
        if ({parado, carga_pronto, palavras_carregadas} !== {2'b01, 10'd0}) begin
            fails++; $display("FAIL reload_entry: got parado/pronto=%b palavras=%0d, required 01 0",
                              {parado, carga_pronto}, palavras_carregadas);
        end
        mptr = 1;
        for (int i = 0; i < 150; i++) begin
            carga_dado = 32'h1000_0000 + 32'(i);
            if (mptr <= 140) begin
                wq.push_back({32'(mptr), carga_dado});
                exp_mem[mptr] = carga_dado;
                mptr++;
            end
            tick();
        end
        carga_valido = 1'b0;
        tests++;
        if (palavras_carregadas !== 10'd140) begin
            fails++; $display("FAIL full_palavras: got %0d, required 140", palavras_carregadas);
        end
        tests++;
        if ({carga_pronto, cpu_habilitado} !== 2'b01) begin
            fails++; $display("FAIL full_state: got pronto/hab=%b, required 01", {carga_pronto, cpu_habilitado});
        end
        tests++;
        if (wq.size() != 0) begin
            fails++; $display("FAIL full_writes: got %0d pending, required 0", wq.size());
        end
        fetch(32'd140);
        busca_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_load();
        reset = 1'b1; tick(); reset = 1'b0;
        mptr = 1;
        load_word(32'h0800_00A1, 1'b0);
        load_word(32'h0800_00A2, 1'b0);
        tests++;
        if (palavras_carregadas !== 10'd2) begin
            fails++; $display("FAIL partial_palavras: got %0d, required 2", palavras_carregadas);
        end
        carga_valido = 1'b1; carga_dado = 32'h0800_00A3; reset = 1'b1;
        tick();
        reset = 1'b0; carga_valido = 1'b0;
        tests++;
        if ({carga_pronto, cpu_habilitado, parado, palavras_carregadas, ciclos_exec} !== {3'b100, 10'd0, 32'd0}) begin
            fails++; $display("FAIL midload_reset: got flags=%b palavras=%0d ciclos=%0d, required 100 0 0",
                              {carga_pronto, cpu_habilitado, parado}, palavras_carregadas, ciclos_exec);
        end
        mptr = 1;
        tests++;
        if (mem_endereco !== 32'd1) begin
            fails++; $display("FAIL midload_ponteiro: got %0d, required 1", mem_endereco);
        end
        load_word(32'h0800_00B1, 1'b0);
        load_word(32'h0800_00B2, 1'b1);
        carga_valido = 1'b0; carga_fim = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        tests++;
`ifdef CICLOS_EXEC_EN
        if (ciclos_exec !== 32'd10) begin
            fails++; $display("FAIL ciclos_exec: got %0d, required 10", ciclos_exec);
        end
`else
        if (ciclos_exec !== 32'd0) begin
            fails++; $display("FAIL ciclos_exec: got %0d, required 0", ciclos_exec);
        end
`endif
        tests++;
        if (wq.size() != 0) begin
            fails++; $display("FAIL midload_writes: got %0d pending, required 0", wq.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) exp_mem[i] = 32'h0;
        test_reset();
        test_load();
        test_fetch_latency();
        test_back_to_back();
        test_addr_error();
        test_halt();
        test_full_load();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
